// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock divider, H/V counters,
// registered blank/sync decode and line/frame strobes with run/drain control.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int CLK_DIV   = 2,
   parameter int CNT_W     = 10
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic             run,
   output logic             pix_en,
   output logic [CNT_W-1:0] posX,
   output logic [CNT_W-1:0] posY,
   output logic             blank,
   output logic             Hsinc,
   output logic             Vsinc,
   output logic             line_start,
   output logic             frame_start,
   output logic             busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W:0]   H_ACT_W  = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0]   V_ACT_W  = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0]   HS_BEG   = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0]   VS_BEG   = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic             HS_ON    = (HSYNC_POL != 0);
   localparam logic             VS_ON    = (VSYNC_POL != 0);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state, state_n;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] x_n, y_n;
   logic             line_n, frame_n, blank_n, hs_n, vs_n;

   assign pix_en = (div_cnt == DIV_LAST);
   assign busy   = (state != IDLE);

   // Next-state, counter advance and decode of the values the registers will hold,
   // so every registered output lines up with the posX/posY it describes.
   always_comb begin
      state_n = state;
      x_n     = posX;
      y_n     = posY;
      line_n  = 1'b0;
      frame_n = 1'b0;
      case (state)
         IDLE: begin
            if (pix_en && run) begin
               state_n = RUN;
               line_n  = 1'b1;
               frame_n = 1'b1;
            end
         end
         RUN, DRAIN: begin
            state_n = run ? RUN : DRAIN;
            if (pix_en) begin
               if (posX == H_LAST) begin
                  x_n    = '0;
                  line_n = 1'b1;
                  if (posY == V_LAST) begin
                     y_n = '0;
                     if (run) frame_n = 1'b1;
                     else     state_n = IDLE;
                  end else begin
                     y_n = posY + 1'b1;
                  end
               end else begin
                  x_n = posX + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      blank_n = !(({1'b0, x_n} < H_ACT_W) && ({1'b0, y_n} < V_ACT_W));
      hs_n    = (({1'b0, x_n} >= HS_BEG) && ({1'b0, x_n} < HS_END)) ? HS_ON : !HS_ON;
      vs_n    = (({1'b0, y_n} >= VS_BEG) && ({1'b0, y_n} < VS_END)) ? VS_ON : !VS_ON;
      if (state_n == IDLE) begin
         blank_n = 1'b1;
         hs_n    = !HS_ON;
         vs_n    = !VS_ON;
      end
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         state       <= IDLE;
         div_cnt     <= '0;
         posX        <= '0;
         posY        <= '0;
         blank       <= 1'b1;
         Hsinc       <= !HS_ON;
         Vsinc       <= !VS_ON;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_n;
         div_cnt     <= pix_en ? '0 : div_cnt + 1'b1;
         posX        <= x_n;
         posY        <= y_n;
         blank       <= blank_n;
         Hsinc       <= hs_n;
         Vsinc       <= vs_n;
         line_start  <= line_n;
         frame_start <= frame_n;
      end
   end

endmodule
